// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// stall masks, FSM encoding and datapath widths.
package pipe_ctrl_pkg;

   localparam int ADDR_W = 32;
   localparam int BUB_W  = 4;
   localparam int WAIT_W = 10;
   localparam int SC_W   = 16;

   // Stage bit positions inside the stall vector, front of the pipe first.
   localparam int ST_PC  = 0;
   localparam int ST_IF  = ST_PC + 1;
   localparam int ST_ID  = ST_IF + 1;
   localparam int ST_EX  = ST_ID + 1;
   localparam int ST_MEM = ST_EX + 1;
   localparam int ST_WB  = ST_MEM + 1;
   localparam int STALL_W = ST_WB + 1;

   // Holding a stage means holding every stage in front of it as well.
   function automatic logic [STALL_W-1:0] stage_mask(input int last);
      logic [STALL_W-1:0] m;
      m = '0;
      for (int i = 0; i < STALL_W; i++) begin
         if (i <= last) m[i] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [STALL_W-1:0] STALL_NONE = '0;
   localparam logic [STALL_W-1:0] STALL_ID   = stage_mask(ST_ID);
   localparam logic [STALL_W-1:0] STALL_EX   = stage_mask(ST_EX);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_ID_STALL = 2'd1,
      S_EX_WAIT  = 2'd2,
      S_FLUSH    = 2'd3
   } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module ctrl_sat_cnt
   import pipe_ctrl_pkg::*;
#(
   parameter int WIDTH = SC_W
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle execute waits
// with timeout, and one-cycle redirect pulses, plus a stalled-cycle counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_BUBBLE = 1,
   parameter int EX_TIMEOUT  = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_stall_req,
   input  logic               ex_busy_req,
   input  logic               ex_done,
   input  logic               flush_req,
   input  logic [ADDR_W-1:0]  flush_pc,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [ADDR_W-1:0]  new_pc,
   output logic               ex_abort,
   output logic [SC_W-1:0]    stall_cycles
);

   localparam logic [BUB_W-1:0]  BUB_INIT  = BUB_W'(LOAD_BUBBLE - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EX_TIMEOUT - 1);

   state_t              r_state;
   logic [BUB_W-1:0]    r_bub_cnt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic                r_flush_pend;
   logic [ADDR_W-1:0]   r_new_pc;
   logic                r_flush;
   logic                r_ex_abort;

   logic [STALL_W-1:0]  w_stall;
   logic [WAIT_W-1:0]   w_wait_inc;
   logic                w_timeout;
   logic                w_stall_any;

   assign w_wait_inc = r_wait_cnt + 1'b1;
   assign w_timeout  = (w_wait_inc == WAIT_LAST);

   // Stall reacts in the same cycle as the request; reset forces it low.
   always_comb begin
      w_stall = STALL_NONE;
      if (!reset) begin
         case (r_state)
            S_RUN: begin
               if (flush_req)         w_stall = STALL_NONE;
               else if (ex_busy_req)  w_stall = STALL_EX;
               else if (id_stall_req) w_stall = STALL_ID;
            end
            S_ID_STALL: w_stall = STALL_ID;
            S_EX_WAIT:  w_stall = ex_done ? STALL_NONE : STALL_EX;
            default:    w_stall = STALL_NONE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_RUN;
         r_bub_cnt    <= '0;
         r_wait_cnt   <= '0;
         r_flush_pend <= 1'b0;
         r_new_pc     <= '0;
         r_flush      <= 1'b0;
         r_ex_abort   <= 1'b0;
      end else begin
         r_flush    <= 1'b0;
         r_ex_abort <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (flush_req) begin
                  r_state  <= S_FLUSH;
                  r_new_pc <= flush_pc;
                  r_flush  <= 1'b1;
               end else if (ex_busy_req) begin
                  r_state    <= S_EX_WAIT;
                  r_wait_cnt <= '0;
               end else if (id_stall_req && (LOAD_BUBBLE > 1)) begin
                  r_state   <= S_ID_STALL;
                  r_bub_cnt <= BUB_INIT;
               end
            end
            S_ID_STALL: begin
               if (flush_req) begin
                  r_state  <= S_FLUSH;
                  r_new_pc <= flush_pc;
                  r_flush  <= 1'b1;
               end else begin
                  r_bub_cnt <= r_bub_cnt - 1'b1;
                  if (r_bub_cnt <= BUB_W'(1)) r_state <= S_RUN;
               end
            end
            S_EX_WAIT: begin
               r_wait_cnt <= w_wait_inc;
               // A redirect arriving mid-wait is parked until execute releases.
               if (flush_req) begin
                  r_new_pc     <= flush_pc;
                  r_flush_pend <= 1'b1;
               end
               if (ex_done || w_timeout) begin
                  r_ex_abort <= !ex_done;
                  if (flush_req || r_flush_pend) begin
                     r_state      <= S_FLUSH;
                     r_flush      <= 1'b1;
                     r_flush_pend <= 1'b0;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_req) begin
                  r_new_pc <= flush_pc;
                  r_flush  <= 1'b1;
               end else begin
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign w_stall_any = (w_stall != STALL_NONE);

   ctrl_sat_cnt #(
      .WIDTH (SC_W)
   ) u_stall_cnt (
      .clk     (clk),
      .i_clr   (reset),
      .i_en    (w_stall_any),
      .o_count (stall_cycles)
   );

   assign stall    = w_stall;
   assign flush    = r_flush;
   assign new_pc   = r_new_pc;
   assign ex_abort = r_ex_abort;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (LOAD_BUBBLE=3, EX_TIMEOUT=8).
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_stall_req;
   logic        ex_busy_req;
   logic        ex_done;
   logic        flush_req;
   logic [31:0] flush_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        ex_abort;
   logic [15:0] stall_cycles;

   typedef struct {
      int          idx;
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        pcchk;
      logic        abort;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   row_idx  = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .LOAD_BUBBLE (3),
      .EX_TIMEOUT  (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id_stall_req (id_stall_req),
      .ex_busy_req  (ex_busy_req),
      .ex_done      (ex_done),
      .flush_req    (flush_req),
      .flush_pc     (flush_pc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .ex_abort     (ex_abort),
      .stall_cycles (stall_cycles)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, req);
      end
   endtask

   // One call = one clock cycle of stimulus plus its expected outputs.
   task automatic row(input logic rst, input logic id, input logic busy, input logic done,
                      input logic freq, input logic [31:0] fpc,
                      input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                      input logic e_pcchk, input logic e_abort, input logic [15:0] e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset        = rst;
      id_stall_req = id;
      ex_busy_req  = busy;
      ex_done      = done;
      flush_req    = freq;
      flush_pc     = fpc;
      e.idx   = row_idx;
      e.stall = e_stall;
      e.flush = e_flush;
      e.pc    = e_pc;
      e.pcchk = e_pcchk;
      e.abort = e_abort;
      e.cnt   = e_cnt;
      exp_q.push_back(e);
      $display("row %0d: rst=%b id=%b busy=%b done=%b freq=%b fpc=%h", row_idx, rst, id, busy, done, freq, fpc);
      row_idx++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall", e.idx, {26'd0, stall}, {26'd0, e.stall});
            chk("flush", e.idx, {31'd0, flush}, {31'd0, e.flush});
            chk("ex_abort", e.idx, {31'd0, ex_abort}, {31'd0, e.abort});
            chk("stall_cycles", e.idx, {16'd0, stall_cycles}, {16'd0, e.cnt});
            if (e.flush || e.pcchk) chk("new_pc", e.idx, new_pc, e.pc);
         end
      end
   end

   initial begin : driver
      reset = 1'b1; id_stall_req = 1'b0; ex_busy_req = 1'b0;
      ex_done = 1'b0; flush_req = 1'b0; flush_pc = '0;
      repeat (2) @(posedge clk);

      //   rst id bsy dn fq fpc          stall  fl pc           pck ab cnt
      row(1, 0, 1, 0, 0, 32'h0,       6'h00, 0, 32'h0,       1, 0, 16'd0);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       1, 0, 16'd0);
      // load-use bubble, 3 cycles
      row(0, 1, 0, 0, 0, 32'h0,       6'h07, 0, 32'h0,       0, 0, 16'd0);
      row(0, 0, 0, 0, 0, 32'h0,       6'h07, 0, 32'h0,       0, 0, 16'd1);
      row(0, 0, 0, 0, 0, 32'h0,       6'h07, 0, 32'h0,       0, 0, 16'd2);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd3);
      // multi-cycle op, done five cycles after start
      row(0, 0, 1, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd3);
      row(0, 0, 0, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd4);
      row(0, 0, 0, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd5);
      row(0, 0, 0, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd6);
      row(0, 0, 0, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd7);
      row(0, 0, 0, 1, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd8);
      row(0, 0, 0, 1, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd8);
      // redirect from RUN beats a simultaneous busy request
      row(0, 0, 1, 0, 1, 32'h100,     6'h00, 0, 32'h0,       0, 0, 16'd8);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 1, 32'h100,     0, 0, 16'd8);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd8);
      // back-to-back redirects
      row(0, 0, 0, 0, 1, 32'h300,     6'h00, 0, 32'h0,       0, 0, 16'd8);
      row(0, 0, 0, 0, 1, 32'h304,     6'h00, 1, 32'h300,     0, 0, 16'd8);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 1, 32'h304,     0, 0, 16'd8);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd8);
      // busy beats load-use; redirect parked during the wait
      row(0, 1, 1, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd8);
      row(0, 0, 0, 0, 1, 32'h200,     6'h0F, 0, 32'h0,       0, 0, 16'd9);
      row(0, 0, 0, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd10);
      row(0, 0, 0, 1, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd11);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 1, 32'h200,     0, 0, 16'd11);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd11);
      // timeout: eight stalled cycles, then abort pulse
      row(0, 0, 1, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd11);
      for (int k = 0; k < 7; k++) begin
         row(0, 0, 0, 0, 0, 32'h0,    6'h0F, 0, 32'h0,       0, 0, 16'(12 + k));
      end
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 1, 16'd19);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd19);
      // redirect pre-empts a load-use bubble
      row(0, 1, 0, 0, 0, 32'h0,       6'h07, 0, 32'h0,       0, 0, 16'd19);
      row(0, 0, 0, 0, 1, 32'h400,     6'h07, 0, 32'h0,       0, 0, 16'd20);
      row(0, 1, 0, 0, 0, 32'h0,       6'h00, 1, 32'h400,     0, 0, 16'd21);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd21);
      // reset in the middle of a wait with a parked redirect
      row(0, 0, 1, 0, 0, 32'h0,       6'h0F, 0, 32'h0,       0, 0, 16'd21);
      row(0, 0, 0, 0, 1, 32'h500,     6'h0F, 0, 32'h0,       0, 0, 16'd22);
      row(1, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       0, 0, 16'd23);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       1, 0, 16'd0);
      row(0, 0, 0, 1, 0, 32'h0,       6'h00, 0, 32'h0,       1, 0, 16'd0);
      row(0, 0, 0, 0, 0, 32'h0,       6'h00, 0, 32'h0,       1, 0, 16'd0);

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter LOAD_BUBBLE, default 1, meaning total stall cycles per decode load-use request (range 1..15).
REQ-002 SHALL have parameter EX_TIMEOUT, default 64, meaning maximum cycles spent in EX_WAIT before abort (range 2..1023).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port id_stall_req  in  1  load-use hazard raised by decode.
REQ-006 SHALL have port ex_busy_req  in  1  multi-cycle op started in execute.
REQ-007 SHALL have port ex_done  in  1  multi-cycle op result valid this cycle.
REQ-008 SHALL have port flush_req  in  1  branch/exception redirect request.
REQ-009 SHALL have port flush_pc  in  32  redirect target, sampled with flush_req.
REQ-010 SHALL have port stall  out  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-011 SHALL have port flush  out  1  registered one-cycle redirect pulse.
REQ-012 SHALL have port new_pc  out  32  redirect target, valid while flush=1.
REQ-013 SHALL have port ex_abort  out  1  registered one-cycle timeout pulse.
REQ-014 SHALL have port stall_cycles  out  16  saturating count of cycles with stall!=0.

Function
REQ-015 SHALL implement FSM states RUN, ID_STALL, EX_WAIT, FLUSH; stall is combinational from state and inputs, all other outputs registered.
REQ-016 RUN request priority SHALL be flush_req > ex_busy_req > id_stall_req.
REQ-017 RUN, flush_req=1: stall=0; next FLUSH; flush_pc latched.
REQ-018 RUN, ex_busy_req=1: stall=6'b001111 same cycle; next EX_WAIT; wait counter cleared.
REQ-019 RUN, id_stall_req=1: stall=6'b000111 same cycle; next ID_STALL with bubble counter=LOAD_BUBBLE-1 if LOAD_BUBBLE>1, else remain RUN.
REQ-020 ID_STALL: stall=6'b000111; counter decrements each cycle; exit to RUN in the cycle after counter reaches 0; flush_req here SHALL pre-empt to FLUSH next cycle.
REQ-021 EX_WAIT: stall=6'b001111 while ex_done=0; the ex_done=1 cycle gives stall=0 and next RUN.
REQ-022 EX_WAIT: wait counter increments per cycle; when it reaches EX_TIMEOUT-1 without ex_done, ex_abort SHALL pulse next cycle and state returns to RUN.
REQ-023 flush_req during EX_WAIT SHALL be held pending (latest flush_pc kept) and taken as FLUSH on EX_WAIT exit.
REQ-024 FLUSH: flush=1, new_pc=latched target, stall=0, one cycle; flush_req in this cycle re-latches and stays FLUSH one more cycle; else RUN.
REQ-025 ex_done outside EX_WAIT SHALL be ignored.
REQ-026 stall_cycles SHALL increment each cycle stall!=0 and hold at 16'hFFFF.

Reset
REQ-027 reset=1 at a clock edge SHALL force state RUN, all counters 0, pending flush cleared, flush=0, new_pc=0, ex_abort=0, stall_cycles=0.
REQ-028 While reset=1, stall SHALL be 0 combinationally, overriding any in-flight stall.

Structure
REQ-029 Shared package SHALL hold stall bit indices, stall masks (ID 6'b000111, EX 6'b001111), state encoding, 32-bit address width.
REQ-030 The saturating counter SHALL be one sub-module, ctrl_sat_cnt (width parameter, enable, synchronous clear).

Verification
REQ-031 LOAD_BUBBLE=3, id_stall_req one cycle -> stall=6'b000111 exactly 3 cycles, stall_cycles=3.
REQ-032 ex_busy_req, ex_done 5 cycles later -> stall=6'b001111 5 cycles, 0 on ex_done cycle, state RUN.
REQ-033 flush_req with flush_pc=32'h0000_0100 in RUN -> next cycle flush=1, new_pc=32'h0000_0100, stall=0.
REQ-034 flush_req (32'h200) during EX_WAIT, ex_done 2 cycles later -> flush=1, new_pc=32'h200 the cycle after EX_WAIT exit.
REQ-035 EX_TIMEOUT=8, no ex_done -> ex_abort=1 one cycle after 8 stalled cycles, then stall=0.
REQ-036 reset asserted mid-EX_WAIT -> same cycle stall=0; after edge all outputs 0, state RUN.
